dense_fc: RTL

//  Fully-connected (dense) layer stage, directly downstream of the max-pooling stage.

---
 rtl/dense_pkg.sv | 33 +++
 rtl/dense_mac.sv | 59 +++++
 rtl/dense_fc.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/dense_pkg.sv
// Shared widths, FSM state encoding and the output shift/saturate helper for the dense layer.
package dense_pkg;

    localparam int DENSE_SIZE_1   = 11;
    localparam int DENSE_SIZE_2   = 22;
    localparam int DENSE_SIZE_3   = 33;
    localparam int DENSE_ADDR_PIX = 13;
    localparam int DENSE_ADDR_WEI = 16;
    localparam int DIM_W          = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic signed [DENSE_SIZE_3-1:0] SAT_MAX = DENSE_SIZE_3'((2 ** (DENSE_SIZE_1 - 1)) - 1);
    localparam logic signed [DENSE_SIZE_3-1:0] SAT_MIN = ~SAT_MAX;

    // Clamp an accumulator value into the signed output range; relu forces negatives to zero.
    function automatic logic signed [DENSE_SIZE_1-1:0] sat_relu(
        input logic signed [DENSE_SIZE_3-1:0] v,
        input logic                           relu
    );
        if (relu && v[DENSE_SIZE_3-1]) return '0;
        if (v > SAT_MAX) return SAT_MAX[DENSE_SIZE_1-1:0];
        if (v < SAT_MIN) return SAT_MIN[DENSE_SIZE_1-1:0];
        return v[DENSE_SIZE_1-1:0];
    endfunction

endpackage

// File: rtl/dense_mac.sv
// Multiply-accumulate datapath: registered product, accumulator, and the shifted/saturated output word.
module dense_mac
    import dense_pkg::*;
#(
    parameter int SIZE_1 = DENSE_SIZE_1,
    parameter int SIZE_2 = DENSE_SIZE_2,
    parameter int SIZE_3 = DENSE_SIZE_3,
    parameter int SHIFT  = 0,
    parameter int RELU   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_vld,
    input  logic signed [SIZE_1-1:0] i_qp,
    input  logic signed [SIZE_1-1:0] i_qw,
    input  logic                     i_clear,
    input  logic                     i_load,
    output logic signed [SIZE_1-1:0] o_dp
);

    logic                     r_vld_p1;
    logic                     r_vld_p2;
    logic signed [SIZE_2-1:0] r_prod_p2;
    logic signed [SIZE_3-1:0] r_acc_p3;
    logic signed [SIZE_1-1:0] r_dp;

    logic signed [SIZE_2-1:0] w_prod;
    logic signed [SIZE_3-1:0] w_prod_ext;
    logic signed [SIZE_3-1:0] w_addend;
    logic signed [SIZE_3-1:0] w_acc_next;
    logic signed [SIZE_3-1:0] w_shifted;

    assign w_prod     = SIZE_2'(i_qp) * SIZE_2'(i_qw);
    assign w_prod_ext = SIZE_3'(r_prod_p2);
    assign w_addend   = r_vld_p2 ? w_prod_ext : SIZE_3'(0);
    assign w_acc_next = r_acc_p3 + w_addend;
    assign w_shifted  = w_acc_next >>> SHIFT;

    // Clearing also flushes the valid pipeline so reads from an aborted run never leak into a new one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1  <= 1'b0;
            r_vld_p2  <= 1'b0;
            r_prod_p2 <= '0;
            r_acc_p3  <= '0;
            r_dp      <= '0;
        end else begin
            // p1: memory data valid; p2: product registered; p3: accumulator updated
            r_vld_p1  <= i_vld & ~i_clear;
            r_vld_p2  <= r_vld_p1 & ~i_clear;
            r_prod_p2 <= w_prod;
            r_acc_p3  <= i_clear ? SIZE_3'(0) : w_acc_next;
            r_dp      <= i_load ? sat_relu(w_shifted, RELU != 0) : SIZE_1'(0);
        end
    end

    assign o_dp = r_dp;

endmodule

// File: rtl/dense_fc.sv
// Fully-connected layer controller: streams the input vector and weight rows, then writes one saturated result per row.
module dense_fc
    import dense_pkg::*;
#(
    parameter int SIZE_1           = DENSE_SIZE_1,
    parameter int SIZE_2           = DENSE_SIZE_2,
    parameter int SIZE_3           = DENSE_SIZE_3,
    parameter int SIZE_address_pix = DENSE_ADDR_PIX,
    parameter int SIZE_address_wei = DENSE_ADDR_WEI,
    parameter int SHIFT            = 0,
    parameter int RELU             = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        dense_en,
    input  logic [SIZE_address_pix-1:0] memstartp,
    input  logic [SIZE_address_wei-1:0] memstartw,
    input  logic [SIZE_address_pix-1:0] memstartzap,
    input  logic [DIM_W-1:0]            in_dim,
    input  logic [DIM_W-1:0]            out_dim,
    output logic [SIZE_address_pix-1:0] read_addressp,
    output logic                        re,
    input  logic signed [SIZE_1-1:0]    qp,
    output logic [SIZE_address_wei-1:0] read_addressw,
    output logic                        re_w,
    input  logic signed [SIZE_1-1:0]    qw,
    output logic [SIZE_address_pix-1:0] write_addressp,
    output logic                        we,
    output logic signed [SIZE_1-1:0]    dp,
    output logic                        STOP
);

    state_t                      r_state;
    logic                        r_re;
    logic                        r_we;
    logic                        r_stop;
    logic                        r_drain;
    logic [SIZE_address_pix-1:0] r_raddrp;
    logic [SIZE_address_wei-1:0] r_raddrw;
    logic [SIZE_address_pix-1:0] r_waddr;
    logic [SIZE_address_pix-1:0] r_pbase;
    logic [SIZE_address_pix-1:0] r_zbase;
    logic [SIZE_address_wei-1:0] r_wptr;
    logic [DIM_W-1:0]            r_in_dim;
    logic [DIM_W-1:0]            r_out_dim;
    logic [DIM_W-1:0]            r_i;
    logic [DIM_W-1:0]            r_j;

    logic w_clear;
    logic w_load;

    assign w_clear = ((r_state == S_IDLE) && dense_en) || (r_state == S_WRITE);
    // The result is latched on the last drain cycle so dp lines up with we in WRITE.
    assign w_load  = (r_state == S_DRAIN) && r_drain && dense_en;

    // r_i counts reads already issued; r_wptr always points at the next weight to fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_re      <= 1'b0;
            r_we      <= 1'b0;
            r_stop    <= 1'b0;
            r_drain   <= 1'b0;
            r_raddrp  <= '0;
            r_raddrw  <= '0;
            r_waddr   <= '0;
            r_pbase   <= '0;
            r_zbase   <= '0;
            r_wptr    <= '0;
            r_in_dim  <= '0;
            r_out_dim <= '0;
            r_i       <= '0;
            r_j       <= '0;
        end else if ((r_state != S_IDLE) && !dense_en) begin
            r_state  <= S_IDLE;
            r_re     <= 1'b0;
            r_we     <= 1'b0;
            r_stop   <= 1'b0;
            r_drain  <= 1'b0;
            r_raddrp <= '0;
            r_raddrw <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (dense_en) begin
                        r_pbase   <= memstartp;
                        r_zbase   <= memstartzap;
                        r_in_dim  <= in_dim;
                        r_out_dim <= out_dim;
                        r_j       <= '0;
                        r_drain   <= 1'b0;
                        r_wptr    <= memstartw;
                        if (out_dim == '0) begin
                            r_state <= S_DONE;
                            r_stop  <= 1'b1;
                        end else if (in_dim == '0) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_state  <= S_READ;
                            r_re     <= 1'b1;
                            r_raddrp <= memstartp;
                            r_raddrw <= memstartw;
                            r_wptr   <= memstartw + SIZE_address_wei'(1);
                            r_i      <= DIM_W'(1);
                        end
                    end
                end
                S_READ: begin
                    if (r_i == r_in_dim) begin
                        r_state <= S_DRAIN;
                        r_re    <= 1'b0;
                        r_drain <= 1'b0;
                    end else begin
                        r_raddrp <= r_pbase + SIZE_address_pix'(r_i);
                        r_raddrw <= r_wptr;
                        r_wptr   <= r_wptr + SIZE_address_wei'(1);
                        r_i      <= r_i + DIM_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (!r_drain) begin
                        r_drain <= 1'b1;
                    end else begin
                        r_drain <= 1'b0;
                        r_state <= S_WRITE;
                        r_we    <= 1'b1;
                        r_waddr <= r_zbase + SIZE_address_pix'(r_j);
                    end
                end
                S_WRITE: begin
                    r_we <= 1'b0;
                    r_j  <= r_j + DIM_W'(1);
                    if ((r_j + DIM_W'(1)) == r_out_dim) begin
                        r_state <= S_DONE;
                        r_stop  <= 1'b1;
                    end else if (r_in_dim == '0) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_state  <= S_READ;
                        r_re     <= 1'b1;
                        r_raddrp <= r_pbase;
                        r_raddrw <= r_wptr;
                        r_wptr   <= r_wptr + SIZE_address_wei'(1);
                        r_i      <= DIM_W'(1);
                    end
                end
                S_DONE: begin
                    r_stop <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    dense_mac #(
        .SIZE_1(SIZE_1),
        .SIZE_2(SIZE_2),
        .SIZE_3(SIZE_3),
        .SHIFT (SHIFT),
        .RELU  (RELU)
    ) u_mac (
        .clk    (clk),
        .rst    (rst),
        .i_vld  (r_re),
        .i_qp   (qp),
        .i_qw   (qw),
        .i_clear(w_clear),
        .i_load (w_load),
        .o_dp   (dp)
    );

    assign read_addressp  = r_raddrp;
    assign re             = r_re;
    assign read_addressw  = r_raddrw;
    assign re_w           = r_re;
    assign write_addressp = r_waddr;
    assign we             = r_we;
    assign STOP           = r_stop;

endmodule
